thin_window_feeder: RTL

Streams packed camera pixel words into a 3-row vertical window for the thinning/average ALU path. Each accepted input word is emitted together with the words at the same column from the two previous rows, as top/center/bottom. The outputs drive the ALU's A/B/C operands. Sits between the camera capture FIFO (upstream) and the ALU operand registers (downstream).

---
 rtl/pixel_pkg.sv | 15 +
 rtl/thin_window_feeder_line_ram.sv | 29 ++
 rtl/thin_window_feeder.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/pixel_pkg.sv
// Shared pixel-path types: packed pixel word, row-fill state encoding and
// the default row length of the thinning window feeder.
package pixel_pkg;

  typedef logic [31:0] pix_word_t;

  typedef enum logic [1:0] {
    FILL0  = 2'd0,
    FILL1  = 2'd1,
    STREAM = 2'd2
  } fill_state_t;

  localparam int THIN_WORDS_PER_ROW_DEF = 80;

endpackage : pixel_pkg

// File: rtl/thin_window_feeder_line_ram.sv
// line_ram: one image row of packed pixel words. Asynchronous read port and
// synchronous write port with write-enable. Contents are never reset; the
// feeder's fill state machine decides when stored data is meaningful.
module line_ram #(
  parameter int DEPTH = 80,
  parameter int WIDTH = 32,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write one word per cycle when enabled.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // Combinational read so the window can be formed in the accept cycle.
  assign rdata_o = mem[raddr_i];

endmodule : line_ram

// File: rtl/thin_window_feeder.sv
// thin_window_feeder: turns a stream of packed pixel words into a 3-row
// vertical window (top = row r-2, center = row r-1, bottom = row r) at the
// same column, feeding the ALU A/B/C operands.
// Optional feature macro: THIN_WINDOW_ZERO_PAD_EN -- when defined, every
// accepted word produces a window, with missing rows during fill forced to 0.
// When undefined, windows start at row 2 of each frame.
module thin_window_feeder
  import pixel_pkg::*;
#(
  parameter int WORDS_PER_ROW = THIN_WORDS_PER_ROW_DEF,
  parameter int WORD_W        = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sof,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_top,
  output logic [WORD_W-1:0] out_center,
  output logic [WORD_W-1:0] out_bottom,
  output logic              out_eol
);

  localparam int               COL_W    = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(WORDS_PER_ROW - 1);

  fill_state_t       state_q, state_d;
  fill_state_t       eff_state;
  logic [COL_W-1:0]  col_q, col_d;
  logic [COL_W-1:0]  eff_col;
  logic              accept;
  logic              produce;
  logic              at_last;

  logic [WORD_W-1:0] old_rd, mid_rd;
  logic [WORD_W-1:0] win_top, win_center;

  logic              out_valid_q, out_valid_d;
  logic [WORD_W-1:0] out_top_q, out_top_d;
  logic [WORD_W-1:0] out_center_q, out_center_d;
  logic [WORD_W-1:0] out_bottom_q, out_bottom_d;
  logic              out_eol_q, out_eol_d;

  // A stalled output register blocks new input; a draining one does not.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Start-of-frame overrides the tracked position: the word is row 0, col 0.
  assign eff_col   = in_sof ? '0 : col_q;
  assign eff_state = in_sof ? FILL0 : state_q;
  assign at_last   = (eff_col == LAST_COL);

  // row_old shifts up from row_mid, row_mid takes the incoming word.
  line_ram #(
    .DEPTH (WORDS_PER_ROW),
    .WIDTH (WORD_W),
    .AW    (COL_W)
  ) u_row_old (
    .clk     (clk),
    .we_i    (accept),
    .waddr_i (eff_col),
    .wdata_i (mid_rd),
    .raddr_i (eff_col),
    .rdata_o (old_rd)
  );

  line_ram #(
    .DEPTH (WORDS_PER_ROW),
    .WIDTH (WORD_W),
    .AW    (COL_W)
  ) u_row_mid (
    .clk     (clk),
    .we_i    (accept),
    .waddr_i (eff_col),
    .wdata_i (in_data),
    .raddr_i (eff_col),
    .rdata_o (mid_rd)
  );

  // Fill state and column position registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FILL0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
    end
  end

  // Column advance and row-fill progression on each accepted word.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    if (accept) begin
      state_d = eff_state;
      if (at_last) begin
        col_d = '0;
        case (eff_state)
          FILL0:   state_d = FILL1;
          FILL1:   state_d = STREAM;
          default: state_d = STREAM;
        endcase
      end else begin
        col_d = eff_col + COL_W'(1);
      end
    end
  end

  // Decide whether this accept yields a window and what its upper rows are.
  always_comb begin
    produce    = 1'b0;
    win_top    = old_rd;
    win_center = mid_rd;
`ifdef THIN_WINDOW_ZERO_PAD_EN
    produce    = accept;
    if (eff_state != STREAM) begin
      win_top = '0;
    end
    if (eff_state == FILL0) begin
      win_center = '0;
    end
`else
    produce    = accept && (eff_state == STREAM);
`endif
  end

  // Output register next state: load on a producing accept, drain otherwise.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_top_d    = out_top_q;
    out_center_d = out_center_q;
    out_bottom_d = out_bottom_q;
    out_eol_d    = out_eol_q;
    if (produce) begin
      out_valid_d  = 1'b1;
      out_top_d    = win_top;
      out_center_d = win_center;
      out_bottom_d = in_data;
      out_eol_d    = at_last;
    end else if (out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  // Output register; cleared immediately on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q  <= 1'b0;
      out_top_q    <= '0;
      out_center_q <= '0;
      out_bottom_q <= '0;
      out_eol_q    <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_top_q    <= out_top_d;
      out_center_q <= out_center_d;
      out_bottom_q <= out_bottom_d;
      out_eol_q    <= out_eol_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_top    = out_top_q;
  assign out_center = out_center_q;
  assign out_bottom = out_bottom_q;
  assign out_eol    = out_eol_q;

endmodule : thin_window_feeder
